// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory port and decode-side head interface of the fetch stage.
// The decode fields (opcode/funct3/funct7) are sliced here from if_instr so every
// consumer sees the same typed view of the head word.
interface fetch_unit_if;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_FENCE  = 7'b0001111,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BR     = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } rv32i_opcode;

    // instruction memory side
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;

    // pipeline control
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    // head entry presented to decode
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = rv32i_opcode'(if_instr[6:0]);
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];

    modport master (
        output imem_read, imem_address,
        input  imem_resp, imem_rdata,
        input  stall, redirect, redirect_pc,
        output if_valid, if_pc, if_instr,
        input  opcode, funct3, funct7
    );

    modport slave (
        input  imem_read, imem_address,
        output imem_resp, imem_rdata,
        output stall, redirect, redirect_pc,
        input  if_valid, if_pc, if_instr,
        input  opcode, funct3, funct7
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage. Owns the PC, runs the imem
// request/response handshake, and buffers fetched words in a circular queue.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode in the same cycle when the queue is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int unsigned PW  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, DISCARD} state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [31:0]   r_pc;
    logic [31:0]   r_req_addr;
    logic          r_pending;

    logic [31:0]   r_q_pc    [FQ_DEPTH];
    logic [31:0]   r_q_instr [FQ_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_read;
    logic [31:0]   w_addr;
    logic [31:0]   w_target;
    logic          w_q_valid;
    logic          w_full;
    logic          w_take;
    logic          w_push;
    logic          w_pop;
    logic          w_bypass;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_target  = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_q_valid = (r_count != '0);
    assign w_full    = (r_count == CW'(FQ_DEPTH));

    // A response is accepted only in RUN; redirect kills it in the same cycle.
    assign w_take    = (r_state == RUN) && bus.imem_resp && !bus.redirect;
    assign w_pop     = w_q_valid && !bus.stall && !bus.redirect;

`ifdef FETCH_BYPASS_EN
    assign w_bypass  = w_take && !w_q_valid;
    assign w_push    = w_take && !(w_bypass && !bus.stall);
`else
    assign w_bypass  = 1'b0;
    assign w_push    = w_take;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_next;
    end

    // FSM next state: DISCARD swallows the one stale response still in flight.
    // A redirect arriving together with that response also returns to RUN,
    // otherwise nothing would be left outstanding to leave DISCARD on.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (bus.redirect && w_read && !bus.imem_resp) w_state_next = DISCARD;
            DISCARD: if (bus.imem_resp) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // FSM outputs: request strobe, address held from issue until the response
    always_comb begin
        w_read = 1'b0;
        if (rst) w_read = r_pending || ((r_state == RUN) && !w_full);
        w_addr = r_pending ? r_req_addr : r_pc;
    end

    // PC, outstanding-request flag and latched request address
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_pending  <= 1'b0;
            r_req_addr <= '0;
        end else begin
            r_pending <= w_read && !bus.imem_resp;
            if (w_read && !r_pending) r_req_addr <= w_addr;
            if (bus.redirect)   r_pc <= w_target;
            else if (w_take)    r_pc <= r_pc + 32'd4;
        end
    end

    // Fetch queue: circular buffer, flushed by redirect
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_pc[r_tail]    <= w_addr;
                r_q_instr[r_tail] <= bus.imem_rdata;
                r_tail            <= ptr_inc(r_tail);
            end
            if (w_pop) r_head <= ptr_inc(r_head);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Head presentation to decode, with optional same-cycle bypass
    always_comb begin
        bus.if_valid = w_q_valid;
        bus.if_pc    = w_q_valid ? r_q_pc[r_head]    : '0;
        bus.if_instr = w_q_valid ? r_q_instr[r_head] : NOP;
        if (w_bypass) begin
            bus.if_valid = 1'b1;
            bus.if_pc    = w_addr;
            bus.if_instr = bus.imem_rdata;
        end
    end

    assign bus.imem_read    = w_read;
    assign bus.imem_address = w_addr;

endmodule
